// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
// Builds a thermometer stall vector from per-stage stall requests and from a
// multicycle operation that runs in stage EX_IDX. A registered one-cycle
// flush carries the redirect target.
// Optional build macro PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_count performance counters. When it is not defined, both outputs
// read zero and no counter registers are built.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no multicycle op running; stall comes from stallreq only
// ST_MC    | multicycle op running; stage EX_IDX and below are held
// ST_FLUSH | one-cycle flush pulse; new_pc valid; stall forced low
module pipe_ctrl #(
  parameter int STAGES = 6,
  parameter int EX_IDX = 3,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_len,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              mc_busy,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MC    = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic              flush_q;
  logic              mc_busy_q;
  logic [STAGES-1:0] req_eff;
  logic [STAGES-1:0] stall_v;
  logic              acc;

  // State, counter and registered outputs. flush and mc_busy are taken from
  // their own flops so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      new_pc_q  <= 32'h0;
      flush_q   <= 1'b0;
      mc_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      new_pc_q  <= new_pc_d;
      flush_q   <= (state_d == ST_FLUSH);
      mc_busy_q <= (state_d == ST_MC);
    end
  end

  // Next state. flush_req wins over everything, including mc_start.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_pc_d = new_pc_q;
    if (flush_req) begin
      state_d  = ST_FLUSH;
      cnt_d    = '0;
      new_pc_d = flush_pc;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mc_start && (mc_len != '0)) begin
            state_d = ST_MC;
            cnt_d   = mc_len;
          end
        end
        ST_MC: begin
          // The counter holds the MC cycles left, including the current one.
          // mc_start is ignored here, so a running op is never reloaded.
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_FLUSH: state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Zero-latency stall. Every stage at or below the highest requester is
  // held. Stall is forced low during reset and during the flush cycle.
  always_comb begin
    req_eff         = stallreq;
    req_eff[EX_IDX] = stallreq[EX_IDX] | mc_busy_q;
    acc             = 1'b0;
    stall_v         = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc        = acc | req_eff[k];
      stall_v[k] = acc;
    end
    if (rst || flush_q) stall_v = '0;
  end

  assign stall   = stall_v;
  assign flush   = flush_q;
  assign new_pc  = new_pc_q;
  assign mc_busy = mc_busy_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Performance counters. They wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 32'h0;
    end else begin
      if (stall_v[0]) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_q)    flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 6, meaning pipeline stage count; bit 0 = PC, bit STAGES-1 = WB.
REQ-002 SHALL have parameter EX_IDX, default 3, meaning stage index that owns multicycle operations.
REQ-003 SHALL have parameter CNT_W, default 6, meaning multicycle length counter width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  async active-high reset.
REQ-005 SHALL have port stallreq  in  STAGES  per-stage stall request; bit k = stage k cannot advance.
REQ-006 SHALL have port mc_start  in  1  one-cycle pulse starting a multicycle op in stage EX_IDX.
REQ-007 SHALL have port mc_len  in  CNT_W  extra cycles the multicycle op needs; sampled with mc_start.
REQ-008 SHALL have port flush_req  in  1  exception/redirect request.
REQ-009 SHALL have port flush_pc  in  32  redirect target; sampled with flush_req.
REQ-010 SHALL have port stall  out  STAGES  stall vector; bit k = hold stage k.
REQ-011 SHALL have port flush  out  1  registered one-cycle flush pulse.
REQ-012 SHALL have port new_pc  out  32  redirect target, valid while flush=1.
REQ-013 SHALL have port mc_busy  out  1  multicycle op in progress.
REQ-014 SHALL have ports stall_cycles and flush_count  out  32 each  performance counters.

Function
REQ-015 SHALL derive req_eff = stallreq OR (mc_busy ? one-hot(EX_IDX) : 0).
REQ-016 SHALL drive stall[k] = 1 for every k <= h, with h = the highest set bit of req_eff; stall = 0 when req_eff = 0; a request at stage 2 with STAGES=6 gives 6'b000111.
REQ-017 SHALL operate a 3-state FSM: IDLE, MC, FLUSH.
REQ-018 SHALL transition IDLE->MC on mc_start with mc_len != 0, loading the counter with mc_len; mc_start with mc_len = 0 SHALL be ignored.
REQ-019 SHALL, in MC, decrement the counter each cycle and return to IDLE in the cycle after the counter reaches 1; mc_busy = 1 exactly while in MC, giving mc_len stall cycles.
REQ-020 SHALL ignore mc_start while in MC (no reload).
REQ-021 SHALL, on flush_req in any state, enter FLUSH next cycle, capturing flush_pc into new_pc and clearing the counter; flush_req has priority over mc_start in the same cycle.
REQ-022 SHALL hold flush = 1 for exactly one cycle in FLUSH, force stall = 0 during that cycle, then return to IDLE; flush_req asserted during FLUSH SHALL re-enter FLUSH with the new flush_pc.
REQ-023 SHALL hold new_pc at its last captured value outside FLUSH.
REQ-024 SHALL produce stall combinationally from current-cycle inputs and state (zero-latency).

Reset
REQ-025 SHALL, on rst=1, asynchronously force FSM to IDLE, counter to 0, flush to 0, new_pc to 32'h0, mc_busy to 0, stall_cycles and flush_count to 0.
REQ-026 SHALL force stall = 0 while rst=1, regardless of stallreq.
REQ-027 SHALL abandon a multicycle op or pending flush on reset assertion mid-operation with no residual pulse after release.

Configuration
REQ-028 SHALL, with PIPE_CTRL_PERF_EN defined, increment stall_cycles every cycle stall[0]=1 and flush_count every cycle flush=1, both wrapping at 2^32.
REQ-029 SHALL, without PIPE_CTRL_PERF_EN, tie stall_cycles and flush_count to 32'h0 and instantiate no counter registers.

Verification
REQ-030 SHALL cover: stallreq=6'b000100, no mc -> stall=6'b000111 same cycle; stallreq=0 -> stall=0.
REQ-031 SHALL cover: mc_start=1, mc_len=4 -> mc_busy=1 and stall=6'b001111 for exactly 4 cycles, then 0.
REQ-032 SHALL cover: flush_req=1, flush_pc=32'hBFC00380 during MC with 2 cycles left -> next cycle flush=1, new_pc=32'hBFC00380, stall=0, mc_busy=0; following cycle flush=0.
REQ-033 SHALL cover: flush_req and mc_start (len=3) in the same cycle -> FLUSH taken, mc_busy never asserts.
REQ-034 SHALL cover: rst pulsed asynchronously mid-MC (counter=5) -> all outputs reset without waiting for clk; after release stall=0, flush=0.
REQ-035 SHALL cover: with PIPE_CTRL_PERF_EN, mc_len=4 plus one flush -> stall_cycles=4, flush_count=1; without the macro both read 0.
